otter_cu_fsm_mc: RTL and testbench

//  Parametrised multicycle control FSM for the OTTER core; successor to the fixed 4-cycle ENCRY sequencer.

---
 rtl/otter_cu_fsm_mc.sv | 179 +++++++++++++++++
 tb/tb_otter_cu_fsm_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm_mc.sv
// Multicycle OTTER control FSM: fetch/execute/writeback with memory-ready stalls and a crypto-unit start/done wait.
// Build option: define CU_XTIMEOUT_EN to force an XWAIT exit (and pulse CU_XERR) after XTIMEOUT cycles without CU_XDONE.
module otter_cu_fsm_mc #(
    parameter int XMIN_CYCLES = 4,
    parameter int CNT_W       = 8,
    parameter int XTIMEOUT    = 64,
    parameter int USE_MEM_RDY = 1
) (
    input  logic             CU_CLK,
    input  logic             CU_RESET_N,
    input  logic             CU_INT,
    input  logic             CU_prevINT,
    input  logic [6:0]       CU_OPCODE,
    input  logic [2:0]       CU_FUNC3,
    input  logic [11:0]      CU_FUNC12,
    input  logic             CU_MEM_RDY,
    input  logic             CU_XDONE,
    output logic             CU_PCWRITE,
    output logic             CU_REGWRITE,
    output logic             CU_MEMWRITE,
    output logic             CU_MEMREAD1,
    output logic             CU_MEMREAD2,
    output logic             CU_intTaken,
    output logic             CU_csrWrite,
    output logic             CU_intCLR,
    output logic             CU_XSTART,
    output logic             CU_XBUSY,
    output logic             CU_XERR,
    output logic [CNT_W-1:0] crypto_count,
    output logic [2:0]       CU_STATE
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXECUTE = 3'd1,
        ST_WB      = 3'd2,
        ST_XWAIT   = 3'd3,
        ST_INTER   = 3'd4
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ENCRY  = 7'b0011100;

    localparam logic [CNT_W-1:0] XMIN_LAST = CNT_W'(XMIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] XTO_CNT   = CNT_W'(XTIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              mem_rdy;
    logic              is_mret;
    logic              writes_rd;
    logic              timeout_hit;
    logic              timeout_exit;
    state_t            ret_state;

    assign mem_rdy   = (USE_MEM_RDY != 0) ? CU_MEM_RDY : 1'b1;
    assign is_mret   = (CU_OPCODE == OP_SYSTEM) && (CU_FUNC3 == 3'b000) && (CU_FUNC12 == 12'h302);
    assign writes_rd = (CU_OPCODE == OP_LUI)   || (CU_OPCODE == OP_AUIPC) ||
                       (CU_OPCODE == OP_JAL)   || (CU_OPCODE == OP_JALR)  ||
                       (CU_OPCODE == OP_OP)    || (CU_OPCODE == OP_OPIMM) ||
                       ((CU_OPCODE == OP_SYSTEM) && !is_mret);
    // Pending interrupts are only honoured at an instruction boundary.
    assign ret_state = (CU_INT || CU_prevINT) ? ST_INTER : ST_FETCH;
    assign CU_STATE  = state;

`ifdef CU_XTIMEOUT_EN
    assign timeout_hit = (crypto_count == XTO_CNT);
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^{XTO_CNT, timeout_exit};
`endif

    always_comb begin
        state_nxt    = state;
        count_nxt    = crypto_count;
        timeout_exit = 1'b0;
        CU_PCWRITE   = 1'b0;
        CU_REGWRITE  = 1'b0;
        CU_MEMWRITE  = 1'b0;
        CU_MEMREAD1  = 1'b0;
        CU_MEMREAD2  = 1'b0;
        CU_intTaken  = 1'b0;
        CU_csrWrite  = 1'b0;
        CU_intCLR    = 1'b0;
        CU_XSTART    = 1'b0;
        CU_XBUSY     = 1'b0;
        case (state)
            ST_FETCH: begin
                CU_MEMREAD1 = 1'b1;
                if (mem_rdy) state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (CU_OPCODE)
                    OP_LOAD: begin
                        CU_MEMREAD2 = 1'b1;
                        if (mem_rdy) state_nxt = ST_WB;
                    end
                    OP_ENCRY: begin
                        CU_XSTART = 1'b1;
                        CU_XBUSY  = 1'b1;
                        count_nxt = CNT_ONE;
                        state_nxt = ST_XWAIT;
                    end
                    default: begin
                        CU_PCWRITE  = 1'b1;
                        CU_intCLR   = 1'b1;
                        CU_REGWRITE = writes_rd;
                        CU_MEMWRITE = (CU_OPCODE == OP_STORE);
                        CU_csrWrite = (CU_OPCODE == OP_SYSTEM) && (CU_FUNC3 == 3'b001);
                        state_nxt   = ret_state;
                    end
                endcase
            end
            ST_WB: begin
                CU_REGWRITE = 1'b1;
                CU_PCWRITE  = 1'b1;
                CU_intCLR   = 1'b1;
                state_nxt   = ret_state;
            end
            ST_XWAIT: begin
                CU_XBUSY = 1'b1;
                if ((crypto_count >= XMIN_LAST) && CU_XDONE) begin
                    CU_PCWRITE  = 1'b1;
                    CU_REGWRITE = 1'b1;
                    CU_intCLR   = 1'b1;
                    count_nxt   = '0;
                    state_nxt   = ret_state;
                end else if (timeout_hit && !CU_XDONE) begin
                    // Forced exit retires the instruction without writing rd.
                    CU_PCWRITE   = 1'b1;
                    CU_intCLR    = 1'b1;
                    timeout_exit = 1'b1;
                    count_nxt    = '0;
                    state_nxt    = ret_state;
                end else if (crypto_count != CNT_MAX) begin
                    count_nxt = crypto_count + CNT_ONE;
                end
            end
            ST_INTER: begin
                CU_intTaken = 1'b1;
                CU_PCWRITE  = 1'b1;
                CU_intCLR   = 1'b1;
                state_nxt   = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge CU_CLK) begin
        if (!CU_RESET_N) begin
            state        <= ST_FETCH;
            crypto_count <= '0;
        end else begin
            state        <= state_nxt;
            crypto_count <= count_nxt;
        end
    end

`ifdef CU_XTIMEOUT_EN
    always_ff @(posedge CU_CLK) begin
        if (!CU_RESET_N) CU_XERR <= 1'b0;
        else             CU_XERR <= timeout_exit;
    end
`else
    assign CU_XERR = 1'b0;
`endif

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Bench for otter_cu_fsm_mc: per-cycle expected output vectors are queued as stimulus is driven and compared at negedge.
module tb_otter_cu_fsm_mc;
    localparam int CNT_W = 8;

    localparam logic [2:0] S_FE = 3'd0, S_EX = 3'd1, S_WB = 3'd2, S_XW = 3'd3, S_IN = 3'd4;
    localparam logic [10:0] PCW = 11'h400, RGW = 11'h200, MW = 11'h100, MR1 = 11'h080,
                            MR2 = 11'h040, ITK = 11'h020, CSR = 11'h010, CLR = 11'h008,
                            XS = 11'h004, XB = 11'h002, XER = 11'h001, NONE = 11'h000;

    logic cu_clk = 1'b0;
    logic cu_reset_n, cu_int, cu_prevint, cu_mem_rdy, cu_xdone;
    logic [6:0] cu_opcode;
    logic [2:0] cu_func3;
    logic [11:0] cu_func12;
    logic pcwrite, regwrite, memwrite, memread1, memread2, int_taken, csr_write, int_clr;
    logic xstart, xbusy, xerr;
    logic [CNT_W-1:0] crypto_count;
    logic [2:0] cu_state;

    logic [21:0] exp_q[$];
    string tag_q[$];
    int n_checks = 0;
    int n_fail = 0;

    otter_cu_fsm_mc #(.XMIN_CYCLES(4), .CNT_W(CNT_W), .XTIMEOUT(8), .USE_MEM_RDY(1)) dut (
        .CU_CLK(cu_clk), .CU_RESET_N(cu_reset_n), .CU_INT(cu_int), .CU_prevINT(cu_prevint),
        .CU_OPCODE(cu_opcode), .CU_FUNC3(cu_func3), .CU_FUNC12(cu_func12),
        .CU_MEM_RDY(cu_mem_rdy), .CU_XDONE(cu_xdone),
        .CU_PCWRITE(pcwrite), .CU_REGWRITE(regwrite), .CU_MEMWRITE(memwrite),
        .CU_MEMREAD1(memread1), .CU_MEMREAD2(memread2), .CU_intTaken(int_taken),
        .CU_csrWrite(csr_write), .CU_intCLR(int_clr), .CU_XSTART(xstart), .CU_XBUSY(xbusy),
        .CU_XERR(xerr), .crypto_count(crypto_count), .CU_STATE(cu_state)
    );

    // clock / reset
    always #5 cu_clk = ~cu_clk;

    logic [21:0] obs;
    assign obs = {cu_state, pcwrite, regwrite, memwrite, memread1, memread2, int_taken,
                  csr_write, int_clr, xstart, xbusy, xerr, crypto_count};

    task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h (st=%0d fl=%h cnt=%0d) exp=%h (st=%0d fl=%h cnt=%0d)",
                     tag, got, got[21:19], got[18:8], got[7:0], exp, exp[21:19], exp[18:8], exp[7:0]);
        end
    endtask

    // scoreboard: compare on the falling edge, away from the state update
    always @(negedge cu_clk) begin
        if (exp_q.size() != 0) check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end

    // driver: inputs already set by the caller; push expectation, then advance one clock
    task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] fl, input int cnt);
        exp_q.push_back({st, fl, CNT_W'(cnt)});
        tag_q.push_back(tag);
        @(posedge cu_clk);
        #2;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] f12);
        cu_opcode = op;
        cu_func3  = f3;
        cu_func12 = f12;
    endtask

    initial begin
        cu_reset_n = 1'b0; cu_int = 1'b0; cu_prevint = 1'b0; cu_mem_rdy = 1'b1; cu_xdone = 1'b0;
        set_ir(7'b0010011, 3'b000, 12'h000);
        repeat (2) @(posedge cu_clk);
        #2;
        cyc("reset", S_FE, MR1, 0);
        cu_reset_n = 1'b1;

        // ADDI
        cyc("addi_fetch", S_FE, MR1, 0);
        cyc("addi_exec", S_EX, PCW | RGW | CLR, 0);

        // LW with fetch stall and two load stalls
        set_ir(7'b0000011, 3'b010, 12'h004);
        cu_mem_rdy = 1'b0;
        cyc("lw_fetch_stall", S_FE, MR1, 0);
        cu_mem_rdy = 1'b1;
        cyc("lw_fetch", S_FE, MR1, 0);
        cu_mem_rdy = 1'b0;
        cyc("lw_exec_stall0", S_EX, MR2, 0);
        cyc("lw_exec_stall1", S_EX, MR2, 0);
        cu_mem_rdy = 1'b1;
        cyc("lw_exec_rdy", S_EX, MR2, 0);
        cyc("lw_wb", S_WB, PCW | RGW | CLR, 0);

        // ENCRY with XDONE held high: exit at minimum occupancy
        set_ir(7'b0011100, 3'b000, 12'h000);
        cu_xdone = 1'b1;
        cyc("enc_fetch", S_FE, MR1, 0);
        cyc("enc_start", S_EX, XS | XB, 0);
        cyc("enc_wait1", S_XW, XB, 1);
        cyc("enc_wait2", S_XW, XB, 2);
        cyc("enc_exit", S_XW, XB | PCW | RGW | CLR, 3);
        cu_xdone = 1'b0;
        cyc("enc_after", S_FE, MR1, 0);

        // ENCRY, early XDONE ignored, exit at count 6 into INTER
        cu_int = 1'b1;
        cyc("enc2_start", S_EX, XS | XB, 0);
        cu_xdone = 1'b1;
        cyc("enc2_w1_early", S_XW, XB, 1);
        cyc("enc2_w2_early", S_XW, XB, 2);
        cu_xdone = 1'b0;
        for (int c = 3; c <= 5; c++) cyc($sformatf("enc2_w%0d", c), S_XW, XB, c);
        cu_xdone = 1'b1;
        cyc("enc2_exit", S_XW, XB | PCW | RGW | CLR, 6);
        cu_xdone = 1'b0;
        cu_int = 1'b0;
        cyc("enc2_inter", S_IN, ITK | PCW | CLR, 0);

        // STORE with latched interrupt
        set_ir(7'b0100011, 3'b010, 12'h008);
        cu_prevint = 1'b1;
        cyc("sw_fetch", S_FE, MR1, 0);
        cyc("sw_exec", S_EX, MW | PCW | CLR, 0);
        cu_prevint = 1'b0;
        cyc("sw_inter", S_IN, ITK | PCW | CLR, 0);

        // CSRRW, MRET, undefined, BRANCH, LUI
        set_ir(7'b1110011, 3'b001, 12'h305);
        cyc("csrrw_fetch", S_FE, MR1, 0);
        cyc("csrrw_exec", S_EX, PCW | RGW | CSR | CLR, 0);
        set_ir(7'b1110011, 3'b000, 12'h302);
        cyc("mret_fetch", S_FE, MR1, 0);
        cyc("mret_exec", S_EX, PCW | CLR, 0);
        set_ir(7'b1111111, 3'b000, 12'h000);
        cyc("undef_fetch", S_FE, MR1, 0);
        cyc("undef_exec", S_EX, PCW | CLR, 0);
        set_ir(7'b1100011, 3'b000, 12'h000);
        cyc("branch_fetch", S_FE, MR1, 0);
        cyc("branch_exec", S_EX, PCW | CLR, 0);
        set_ir(7'b0110111, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
        cyc("lui_fetch", S_FE, MR1, 0);
        cyc("lui_exec", S_EX, PCW | RGW | CLR, 0);

        // reset while waiting on the crypto unit
        set_ir(7'b0011100, 3'b000, 12'h000);
        cyc("rst_fetch", S_FE, MR1, 0);
        cyc("rst_start", S_EX, XS | XB, 0);
        cyc("rst_w1", S_XW, XB, 1);
        cu_reset_n = 1'b0;
        cyc("rst_w2", S_XW, XB, 2);
        cu_reset_n = 1'b1;
        cyc("rst_after", S_FE, MR1, 0);

`ifdef CU_XTIMEOUT_EN
        // timeout with XDONE never asserted
        cyc("to_start", S_EX, XS | XB, 0);
        for (int c = 1; c <= 7; c++) cyc($sformatf("to_w%0d", c), S_XW, XB, c);
        cyc("to_exit", S_XW, XB | PCW | CLR, 8);
        cyc("to_xerr", S_FE, MR1 | XER, 0);
        cyc("to_xerr_clear", S_FE, MR1, 0);
`endif

        @(negedge cu_clk);
        #1;
        check_eq("queue_drained", 22'(exp_q.size()), 22'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
